// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package rr_arb_pkg;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Modulo-n increment: wraps from n-1 to 0, never at a power of two.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    if (idx >= n - 32'd1) begin
      nxt = 32'd0;
    end else begin
      nxt = idx + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Rotating priority finder: first eligible index after ptr, wrapping modulo N.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int P = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [P-1:0] ptr,
  output logic         found,
  output logic [P-1:0] winner
);

  // Walk ptr+1 .. ptr in priority order; the first hit wins.
  always_comb begin
    int unsigned idx_v;
    logic [P-1:0] idx_p;
    found  = 1'b0;
    winner = ptr;
    idx_v  = 32'(ptr);
    idx_p  = ptr;
    for (int k = 0; k < N; k++) begin
      idx_v = next_idx(idx_v, N);
      idx_p = P'(idx_v);
      if (!found && eligible[idx_p]) begin
        found  = 1'b1;
        winner = idx_p;
      end else begin
        found  = found;
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter in front of a shared N:1 mux with a one-entry output register.
// Optional burst locking is enabled by defining RR_ARB_LOCK_EN.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int P = $clog2(N),
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [P-1:0]   sel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [P-1:0]   out_src
);

  logic [P-1:0] ptr_r;
  logic         out_valid_r;
  logic [W-1:0] out_data_r;
  logic [P-1:0] out_src_r;
  logic [N-1:0] eligible_s;
  logic [N-1:0] req_ready_s;
  logic [W-1:0] mux_data_s;
  logic [P-1:0] win_s;
  logic         found_s;
  logic         can_load_s;
  logic         grant_s;

  assign can_load_s = !out_valid_r || out_ready;
  // rst_n gates the grant so no requester sees ready while reset is held.
  assign grant_s    = rst_n && can_load_s && found_s;

`ifdef RR_ARB_LOCK_EN
  lock_state_e  lock_r;
  logic [P-1:0] owner_r;

  // Restrict eligibility to the burst owner while locked.
  always_comb begin
    eligible_s = {N{1'b0}};
    if (lock_r == LOCKED) begin
      eligible_s[owner_r] = req_valid[owner_r];
    end else begin
      eligible_s = req_valid;
    end
  end

  // Lock state: a non-last beat locks onto its requester until its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r  <= UNLOCKED;
      owner_r <= {P{1'b0}};
    end else if (grant_s) begin
      owner_r <= win_s;
      if (req_last[win_s]) begin
        lock_r <= UNLOCKED;
      end else begin
        lock_r <= LOCKED;
      end
    end else begin
      lock_r  <= lock_r;
      owner_r <= owner_r;
    end
  end
`else
  logic unused_last_s;
  assign unused_last_s = ^req_last;

  // Every valid requester competes on every cycle.
  always_comb begin
    eligible_s = req_valid;
  end
`endif

  rr_arb_pick #(
    .N(N),
    .P(P)
  ) u_pick (
    .eligible(eligible_s),
    .ptr     (ptr_r),
    .found   (found_s),
    .winner  (win_s)
  );

  // One-hot ready to the winner, only when a grant actually happens.
  always_comb begin
    req_ready_s = {N{1'b0}};
    if (grant_s) begin
      req_ready_s[win_s] = 1'b1;
    end else begin
      req_ready_s = {N{1'b0}};
    end
  end

  // Shared data mux; only feeds the output register.
  always_comb begin
    mux_data_s = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (win_s == P'(i)) begin
        mux_data_s = req_data[i*W +: W];
      end else begin
        mux_data_s = mux_data_s;
      end
    end
  end

  // Output register and last-winner pointer; load and drain may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_src_r   <= {P{1'b0}};
      ptr_r       <= P'(N - 1);
    end else if (grant_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= mux_data_s;
      out_src_r   <= win_s;
      ptr_r       <= win_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_src_r   <= out_src_r;
      ptr_r       <= ptr_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_src_r   <= out_src_r;
      ptr_r       <= ptr_r;
    end
  end

  assign req_ready = req_ready_s;
  assign sel       = grant_s ? win_s : ptr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;

endmodule
